// File: rtl/button_conditioner.sv
// button_conditioner
//   Front end for the clock's push buttons. Each of the five raw, asynchronous
//   button levels is synchronised (two flops) and debounced. Every accepted press
//   produces one registered single-cycle pulse. Buttons enabled in REPEAT_MASK
//   also auto-repeat while held.
// Ports
//   clk             system clock, all logic on posedge
//   reset           synchronous, active-low reset
//   raw_*           raw button levels (asynchronous)
//   mode_btn .. set_alarm_btn   press / repeat pulses, one cycle wide
//   held[4:0]       debounced levels {set_alarm,set_timer,add_minute,add_hour,mode}
module button_conditioner #(
    parameter int unsigned DEB_CYCLES    = 2,
    parameter int unsigned HOLD_CYCLES   = 4,
    parameter int unsigned REPEAT_CYCLES = 2,
    parameter logic [4:0]  REPEAT_MASK   = 5'b00110
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_mode,
    input  logic       raw_add_hour,
    input  logic       raw_add_minute,
    input  logic       raw_set_timer,
    input  logic       raw_set_alarm,
    output logic       mode_btn,
    output logic       add_hour,
    output logic       add_minute,
    output logic       set_timer_btn,
    output logic       set_alarm_btn,
    output logic [4:0] held
);

    localparam int unsigned DW   = $clog2(DEB_CYCLES + 1);
    localparam int unsigned HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HW   = $clog2(HMAX + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPress, StRepeat} state_t;

    logic [4:0]    raw;
    logic [4:0]    sync1_q;
    logic [4:0]    sync2_q;
    logic [4:0]    db_q;
    logic [4:0]    db_d;
    logic [DW-1:0] cnt_q [5];
    logic [DW-1:0] cnt_d [5];
    logic [HW-1:0] hcnt_q [5];
    state_t        state_q [5];
    logic [4:0]    pulse_q;

    assign raw = {raw_set_alarm, raw_set_timer, raw_add_minute, raw_add_hour, raw_mode};

    // Debounce next state: a level change is taken only after the synchronised
    // input has disagreed with the debounced level for DEB_CYCLES edges in a row.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // The press FSM looks at db_d so the first pulse is registered on the same
    // edge that the debounced level rises, and release suppresses any pulse due
    // on the falling edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            pulse_q <= '0;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i]   <= '0;
                hcnt_q[i]  <= '0;
                state_q[i] <= StIdle;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i]   <= cnt_d[i];
                pulse_q[i] <= 1'b0;
                case (state_q[i])
                    StIdle: begin
                        hcnt_q[i] <= '0;
                        if (db_d[i] && !db_q[i]) begin
                            pulse_q[i] <= 1'b1;
                            state_q[i] <= StPress;
                        end
                    end
                    StPress: begin
                        if (!db_d[i]) begin
                            state_q[i] <= StIdle;
                            hcnt_q[i]  <= '0;
                        end else if (REPEAT_MASK[i] && hcnt_q[i] == HOLD_LAST) begin
                            pulse_q[i] <= 1'b1;
                            state_q[i] <= StRepeat;
                            hcnt_q[i]  <= '0;
                        end else if (hcnt_q[i] != HOLD_SAT) begin
                            // Saturates for non-repeating buttons held indefinitely.
                            hcnt_q[i] <= hcnt_q[i] + 1'b1;
                        end
                    end
                    StRepeat: begin
                        if (!db_d[i]) begin
                            state_q[i] <= StIdle;
                            hcnt_q[i]  <= '0;
                        end else if (hcnt_q[i] == REP_LAST) begin
                            pulse_q[i] <= 1'b1;
                            hcnt_q[i]  <= '0;
                        end else begin
                            hcnt_q[i] <= hcnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_q[i] <= StIdle;
                        hcnt_q[i]  <= '0;
                    end
                endcase
            end
        end
    end

    assign mode_btn      = pulse_q[0];
    assign add_hour      = pulse_q[1];
    assign add_minute    = pulse_q[2];
    assign set_timer_btn = pulse_q[3];
    assign set_alarm_btn = pulse_q[4];
    assign held          = db_q;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    localparam int DEB    = 2;
    localparam int HOLD   = 4;
    localparam int REPEAT = 2;
    localparam logic [4:0] MASK = 5'b00110;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] raw;
    logic       mode_btn, add_hour, add_minute, set_timer_btn, set_alarm_btn;
    logic [4:0] held;
    logic [4:0] dut_p;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    button_conditioner dut (
        .clk           (clk),
        .reset         (reset),
        .raw_mode      (raw[0]),
        .raw_add_hour  (raw[1]),
        .raw_add_minute(raw[2]),
        .raw_set_timer (raw[3]),
        .raw_set_alarm (raw[4]),
        .mode_btn      (mode_btn),
        .add_hour      (add_hour),
        .add_minute    (add_minute),
        .set_timer_btn (set_timer_btn),
        .set_alarm_btn (set_alarm_btn),
        .held          (held)
    );

    assign dut_p = {set_alarm_btn, set_timer_btn, add_minute, add_hour, mode_btn};

    // Reference model: raw seen at an edge reaches the debouncer two edges later;
    // the debounced level flips after DEB consecutive disagreeing samples; pulses
    // are derived from the age (edges since accept) of the current press.
    logic [4:0] m_h0, m_h1, m_db, m_pulse;
    int         m_run [5];
    int         m_age [5];
    int         pcount [5];

    task automatic model_update(input logic rst, input logic [4:0] rw);
        if (!rst) begin
            m_h0 = '0; m_h1 = '0; m_db = '0; m_pulse = '0;
            for (int i = 0; i < 5; i++) begin
                m_run[i] = 0;
                m_age[i] = -1;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                logic s, old;
                s   = m_h1[i];
                old = m_db[i];
                if (s != m_db[i]) m_run[i]++;
                else m_run[i] = 0;
                if (m_run[i] == DEB) begin
                    m_db[i]  = s;
                    m_run[i] = 0;
                end
                if (m_db[i] && !old) m_age[i] = 0;
                else if (m_db[i]) m_age[i]++;
                else m_age[i] = -1;
                m_pulse[i] = m_db[i] && (m_age[i] == 0 ||
                             (MASK[i] && m_age[i] >= HOLD && (m_age[i] - HOLD) % REPEAT == 0));
            end
            m_h1 = m_h0;
            m_h0 = rw;
        end
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %b want %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d want %0d", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle, advance the model, then compare 1 time unit after the edge.
    task automatic step(input logic rst, input logic [4:0] rw);
        reset = rst;
        raw   = rw;
        @(posedge clk);
        model_update(rst, rw);
        #1;
        cyc++;
        for (int i = 0; i < 5; i++) pcount[i] += int'(dut_p[i]);
        check("pulses", dut_p, m_pulse);
        check("held", held, m_db);
    endtask

    typedef struct {
        logic       rst;
        logic [4:0] raw;
        logic [4:0] pulse;
        logic [4:0] held;
    } vec_t;

    vec_t vec [21];

    initial begin
        int first;
        logic [4:0] r;

        // Hand-derived per-cycle vectors: reset, mode press/release, one-cycle
        // glitch on add_minute, simultaneous add_hour+set_alarm released exactly
        // when the first repeat would have been due.
        vec[0]  = '{1'b0, 5'b00000, 5'b00000, 5'b00000};
        vec[1]  = '{1'b0, 5'b00000, 5'b00000, 5'b00000};
        vec[2]  = '{1'b1, 5'b00001, 5'b00000, 5'b00000};
        vec[3]  = '{1'b1, 5'b00001, 5'b00000, 5'b00000};
        vec[4]  = '{1'b1, 5'b00001, 5'b00000, 5'b00000};
        vec[5]  = '{1'b1, 5'b00001, 5'b00001, 5'b00001};
        vec[6]  = '{1'b1, 5'b00001, 5'b00000, 5'b00001};
        vec[7]  = '{1'b1, 5'b00001, 5'b00000, 5'b00001};
        vec[8]  = '{1'b1, 5'b00100, 5'b00000, 5'b00001};
        vec[9]  = '{1'b1, 5'b00000, 5'b00000, 5'b00001};
        vec[10] = '{1'b1, 5'b00000, 5'b00000, 5'b00001};
        vec[11] = '{1'b1, 5'b00000, 5'b00000, 5'b00000};
        vec[12] = '{1'b1, 5'b10010, 5'b00000, 5'b00000};
        vec[13] = '{1'b1, 5'b10010, 5'b00000, 5'b00000};
        vec[14] = '{1'b1, 5'b10010, 5'b00000, 5'b00000};
        vec[15] = '{1'b1, 5'b10010, 5'b10010, 5'b10010};
        vec[16] = '{1'b1, 5'b00000, 5'b00000, 5'b10010};
        vec[17] = '{1'b1, 5'b00000, 5'b00000, 5'b10010};
        vec[18] = '{1'b1, 5'b00000, 5'b00000, 5'b10010};
        vec[19] = '{1'b1, 5'b00000, 5'b00000, 5'b00000};
        vec[20] = '{1'b1, 5'b00000, 5'b00000, 5'b00000};

        for (int i = 0; i < 5; i++) pcount[i] = 0;
        reset = 1'b0;
        raw   = '0;
        model_update(1'b0, '0);

        for (int v = 0; v < 21; v++) begin
            reset = vec[v].rst;
            raw   = vec[v].raw;
            @(posedge clk);
            model_update(vec[v].rst, vec[v].raw);
            #1;
            cyc++;
            check("tbl_pulses", dut_p, vec[v].pulse);
            check("tbl_held", held, vec[v].held);
        end

        // add_minute held 14 cycles: pulses at ages 0,4,6,8,10,12, none after release.
        for (int i = 0; i < 5; i++) pcount[i] = 0;
        for (int k = 0; k < 14; k++) step(1'b1, 5'b00100);
        for (int k = 0; k < 8; k++) step(1'b1, 5'b00000);
        check_int("repeat_count_add_minute", pcount[2], 6);
        check_int("held_add_minute_released", int'(held[2]), 0);

        // set_timer held 14 cycles: exactly one pulse.
        for (int i = 0; i < 5; i++) pcount[i] = 0;
        for (int k = 0; k < 14; k++) step(1'b1, 5'b01000);
        for (int k = 0; k < 8; k++) step(1'b1, 5'b00000);
        check_int("single_pulse_set_timer", pcount[3], 1);

        // Reset mid-repeat, then release reset with the button still down.
        for (int k = 0; k < 10; k++) step(1'b1, 5'b00100);
        step(1'b0, 5'b00100);
        check("reset_mid_repeat_pulses", dut_p, 5'b00000);
        check("reset_mid_repeat_held", held, 5'b00000);
        first = -1;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 5'b00100);
            if (first < 0 && add_minute) first = k;
        end
        check_int("post_reset_first_pulse_edge", first, 3);
        for (int k = 0; k < 6; k++) step(1'b1, 5'b00000);

        // Randomised stimulus against the model.
        r = '0;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, 6) == 0) r[i] = ~r[i];
            end
            step(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
